fpcvt_sched: RTL and testbench

Round-robin scheduler that shares one FPCVT 12-bit-to-floating-point converter among N_REQ requesters. It accepts one operand at a time over a valid/ready handshake, registers it, and drives it through the combinational FPCVT instance. It returns the registered sign/exponent/fraction result, tagged with the requester ID, over a second valid/ready handshake. It sits between the sample sources (switch/ADC capture blocks) and the display/consumer path.

---
 rtl/fpcvt_sched.sv | 164 ++++++++++++++++
 tb/tb_fpcvt_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_sched.sv
// Round-robin scheduler sharing one 12-bit two's-complement to (S,E,F) float converter
// among N_REQ requesters; valid/ready on both the request and the response side.
module fpcvt_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [12*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_s,
  output logic [2:0]            rsp_e,
  output logic [3:0]            rsp_f,
  output logic                  busy,
  output logic [15:0]           conv_count
);

  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   ptr_reg;
  logic [11:0]       op_reg;
  logic [ID_W-1:0]   id_reg;
  logic              rsp_valid_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              rsp_s_reg;
  logic [2:0]        rsp_e_reg;
  logic [3:0]        rsp_f_reg;
  logic [15:0]       conv_count_reg;

  logic [11:0]       req_word [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_word
      assign req_word[gi] = req_data[12*gi +: 12];
    end
  endgenerate

  // Arbiter: first valid requester at or above ptr_reg, wrapping around.
  logic            grant_any;
  logic [ID_W-1:0] grant_id;

  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  logic accept;
  assign accept = (state_reg == IDLE) && grant_any;

  always_comb begin
    req_ready = '0;
    if (!rst && accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = CONVERT;
      CONVERT: state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Converter: normalise the magnitude so its leading one sits at bit 11,
  // keep four bits, round half-up on the next bit, renormalise or saturate on carry.
  logic [11:0] mag;
  logic [3:0]  lz;
  logic [11:0] norm;
  logic [3:0]  e_raw;
  logic [4:0]  f_sum;
  logic        cvt_s;
  logic [2:0]  cvt_e;
  logic [3:0]  cvt_f;

  always_comb begin
    cvt_s = op_reg[11];
    if (!op_reg[11])            mag = op_reg;
    else if (op_reg == 12'h800) mag = 12'h7FF;
    else                        mag = -op_reg;
    lz = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (mag[i]) lz = 4'(11 - i);
    end
    norm  = mag << lz;
    e_raw = 4'd8 - lz;
    f_sum = {1'b0, norm[11:8]} + 5'(norm[7]);
    cvt_e = '0;
    cvt_f = '0;
    if (lz > 4'd8) begin
      cvt_f = mag[3:0];
    end else if (f_sum[4]) begin
      if (e_raw == 4'd7) begin
        cvt_e = 3'd7;
        cvt_f = 4'd15;
      end else begin
        cvt_e = e_raw[2:0] + 3'd1;
        cvt_f = 4'd8;
      end
    end else begin
      cvt_e = e_raw[2:0];
      cvt_f = f_sum[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg        <= '0;
      op_reg         <= '0;
      id_reg         <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= '0;
      rsp_s_reg      <= 1'b0;
      rsp_e_reg      <= '0;
      rsp_f_reg      <= '0;
      conv_count_reg <= '0;
    end else begin
      if (accept) begin
        op_reg <= req_word[grant_id];
        id_reg <= grant_id;
      end
      if (state_reg == CONVERT) begin
        rsp_valid_reg <= 1'b1;
        rsp_id_reg    <= id_reg;
        rsp_s_reg     <= cvt_s;
        rsp_e_reg     <= cvt_e;
        rsp_f_reg     <= cvt_f;
      end
      if (state_reg == HOLD && rsp_valid_reg && rsp_ready) begin
        rsp_valid_reg  <= 1'b0;
        ptr_reg        <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;
        conv_count_reg <= conv_count_reg + 16'd1;
      end
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_id     = rsp_id_reg;
  assign rsp_s      = rsp_s_reg;
  assign rsp_e      = rsp_e_reg;
  assign rsp_f      = rsp_f_reg;
  assign busy       = (state_reg != IDLE);
  assign conv_count = conv_count_reg;

endmodule

// File: tb/tb_fpcvt_sched.sv
// Scoreboard bench for fpcvt_sched: a cycle model predicts grants and results,
// directed scenarios plus a short random phase.
module tb_fpcvt_sched;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [12*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic           rsp_s;
  logic [2:0]     rsp_e;
  logic [3:0]     rsp_f;
  logic           busy;
  logic [15:0]    conv_count;

  fpcvt_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_e(rsp_e), .rsp_f(rsp_f),
    .busy(busy), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: smallest E whose half-up rounded quotient fits in 4 bits.
  function automatic logic [7:0] ref_cvt(input logic [11:0] d);
    int v, m, e, f;
    logic s;
    v = int'($signed(d));
    s = (v < 0);
    m = s ? -v : v;
    if (m > 2047) m = 2047;
    f = m;
    for (e = 0; e < 8; e++) begin
      f = (e == 0) ? m : ((m + (1 << (e - 1))) >> e);
      if (f < 16) break;
    end
    if (e == 8) begin
      e = 7;
      f = 15;
    end
    return {s, e[2:0], f[3:0]};
  endfunction

  // Cycle model, evaluated mid-cycle.
  logic [9:0] sb[$];
  int         grant_log[$];
  int         m_state = 0;
  int         m_ptr = 0;
  int         m_count = 0;
  logic [N-1:0] last_grant = '0;
  logic [N-1:0] sticky = '0;

  always @(negedge clk) begin
    int exp_id, idx;
    logic [N-1:0] exp_oh;
    last_grant = req_ready;
    if (rst) begin
      check("rst_ready", req_ready, 0);
      m_state = 0;
      m_ptr = 0;
      m_count = 0;
      sb.delete();
    end else begin
      check("busy", busy, (m_state != 0));
      check("count", conv_count, m_count);
      case (m_state)
        0: begin
          check("idle_valid", rsp_valid, 0);
          exp_id = -1;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (exp_id < 0 && req_valid[idx]) exp_id = idx;
          end
          exp_oh = (exp_id >= 0) ? N'(1 << exp_id) : '0;
          check("grant", req_ready, exp_oh);
          for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
          if (exp_id >= 0) begin
            sb.push_back({exp_id[1:0], ref_cvt(req_data[12*exp_id +: 12])});
            m_state = 1;
          end
        end
        1: begin
          check("cvt_valid", rsp_valid, 0);
          check("cvt_ready", req_ready, 0);
          m_state = 2;
        end
        default: begin
          check("hold_valid", rsp_valid, 1);
          check("hold_ready", req_ready, 0);
          if (sb.size() > 0) begin
            check("rsp", {rsp_id, rsp_s, rsp_e, rsp_f}, sb[0]);
            if (rsp_ready) begin
              m_ptr = (int'(sb[0][9:8]) + 1) % N;
              m_count = (m_count + 1) % 65536;
              void'(sb.pop_front());
              m_state = 0;
            end
          end
        end
      endcase
    end
  end

  // Advance one clock; granted non-sticky requesters withdraw.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (last_grant[i] && !sticky[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [11:0] d);
    req_data[12*i +: 12] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sticky = '0;
    req_valid = '0;
    cycle();
    cycle();
    rst = 1'b0;
    grant_log.delete();
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 200; c++) begin
      if (req_valid == '0 && m_state == 0 && sb.size() == 0) begin
        done = 1;
        break;
      end
      cycle();
    end
    if (!done) check("timeout_idle", 0, 1);
  endtask

  task automatic wait_rsp_valid();
    bit done = 0;
    for (int c = 0; c < 50; c++) begin
      if (rsp_valid) begin
        done = 1;
        break;
      end
      cycle();
    end
    if (!done) check("timeout_rsp", 0, 1);
  endtask

  initial begin
    // Reset with every requester asserting
    sticky = '1;
    for (int i = 0; i < N; i++) set_req(i, 12'h000);
    rsp_ready = 1'b1;
    cycle();
    cycle();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_count", conv_count, 0);
    rst = 1'b0;
    grant_log.delete();
    cycle();
    sticky = '0;
    req_valid = '0;
    wait_idle();
    check("first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Single request
    do_reset();
    set_req(2, 12'h02E);
    wait_idle();
    check("single_count", conv_count, 1);

    // Contention
    do_reset();
    set_req(0, 12'd11);
    set_req(1, 12'd128);
    set_req(2, 12'd2047);
    set_req(3, 12'h800);
    wait_idle();
    check("cont_n", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("cont_order", grant_log[i], i);
    check("cont_count", conv_count, 4);

    // Backpressure
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 12'd417);
    set_req(1, 12'd300);
    set_req(2, 12'hF00);
    wait_rsp_valid();
    repeat (5) cycle();
    check("bp_count0", conv_count, 0);
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    check("bp_count1", conv_count, 1);
    check("bp_valid", rsp_valid, 0);
    repeat (4) cycle();
    rsp_ready = 1'b1;
    wait_idle();

    // Fairness with continuous requesters
    do_reset();
    sticky = 4'b1001;
    set_req(0, 12'd415);
    set_req(3, 12'hE5F);
    for (int c = 0; c < 40 && grant_log.size() < 4; c++) cycle();
    check("fair_n", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("fair_order", grant_log[i], (i % 2 == 0) ? 0 : 3);
    sticky = '0;
    req_valid = '0;
    wait_idle();

    // Reset while holding a result
    do_reset();
    rsp_ready = 1'b0;
    set_req(1, 12'd1921);
    wait_rsp_valid();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rh_valid", rsp_valid, 0);
    check("rh_count", conv_count, 0);
    grant_log.delete();
    rsp_ready = 1'b1;
    set_req(1, 12'd5);
    set_req(2, 12'd1000);
    wait_idle();
    check("rh_first", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    check("rh_count2", conv_count, 2);

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 12'($urandom));
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
